iob_wishbone2iob: RTL and testbench
===================================

Name: iob_wishbone2iob

Overview:
Wishbone classic slave to IOb native master bridge. It is the counterpart of the IOb-to-Wishbone bridge and lets Wishbone masters, such as the ethmac DMA master port, reach IOb peripherals and memory. One transfer is outstanding at a time. Request fields are registered, `valid_o` is issued as a single-cycle pulse, and `rdata_i` is captured on `ready_i`. A missing response is terminated with `wb_err_o` after a bounded timeout.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; the strobe/select width is DATA_W/8.
- TIMEOUT, 255, maximum cycles to wait for `ready_i`, counted from the `valid_o` cycle inclusive. 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous reset, active-low.
- wb_rst_i  in  1  Wishbone synchronous reset, active-high.
- wb_adr_i  in  ADDR_W  Wishbone address.
- wb_dat_i  in  DATA_W  Wishbone write data.
- wb_sel_i  in  DATA_W/8  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  DATA_W  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  transfer error (timeout).
- valid_o  out  1  IOb request pulse.
- address_o  out  ADDR_W  IOb address.
- wdata_o  out  DATA_W  IOb write data.
- wstrb_o  out  DATA_W/8  IOb write strobes; all zero means read.
- rdata_i  in  DATA_W  IOb read data.
- ready_i  in  1  IOb response pulse.

Behaviour:
- Reset: `arst_n_i` low clears everything asynchronously. `wb_rst_i` high clears the same state synchronously. After either reset, every output is 0, state is IDLE, and the abort flag and timeout counter are 0.
- FSM states: IDLE, REQ, WAIT, ACK, ERR. Encoding is free.
- IDLE:
  - On `wb_cyc_i & wb_stb_i`, register `address_o <= wb_adr_i` and `wdata_o <= wb_dat_i`.
  - Register `wstrb_o <= wb_we_i ? wb_sel_i : 0` and store `we`; clear abort; go to REQ.
  - `ready_i` in IDLE is ignored, including stale responses after a timeout or reset.
- REQ:
  - `valid_o = 1` for exactly this cycle; the counter is set to 1.
  - If `ready_i`, go to ACK.
  - Else if TIMEOUT==1, go to ERR.
  - Else go to WAIT.
- WAIT:
  - `valid_o = 0`; `address_o`, `wdata_o` and `wstrb_o` are held stable.
  - If `ready_i`, go to ACK.
  - Else, when TIMEOUT≠0 and the counter equals TIMEOUT, go to ERR.
  - Otherwise increment the counter (saturating, width $clog2(TIMEOUT+1)).
  - `ready_i` takes priority over timeout in the same cycle.
- Read capture: on `ready_i` in REQ/WAIT with `we==0`, `wb_dat_o <= rdata_i`. `wb_dat_o` holds until the next read capture; writes leave it unchanged. Reads ignore `wb_sel_i`; the full word is returned.
- ACK: `wb_ack_o = !abort` for exactly one cycle; go to IDLE.
- ERR: `wb_err_o = !abort` for exactly one cycle; go to IDLE. The IOb transfer is considered dropped.
- Abort:
  - If `wb_cyc_i` is low in any REQ or WAIT cycle, set abort.
  - The IOb side still completes or times out, but no `wb_ack_o`/`wb_err_o` is issued and `wb_dat_o` is not updated.
- `wb_ack_o` and `wb_err_o` are registered, never both high, and never high outside ACK/ERR.
- Latency: with `stb` sampled at edge N, `valid_o` is high in cycle N.
  - `ready_i` in that same cycle gives `wb_ack_o` in cycle N+1.
  - Minimum Wishbone cycle is 3 clocks including the ACK cycle.
- Back-to-back: a `stb` still high in the cycle after ACK/ERR (IDLE) starts a new transfer.
- `wb_rst_i` in any state returns to IDLE on the next edge with no `ack`/`err`.

Test Plan:
- Write `adr=0x40`, `dat=0xDEADBEEF`, `sel=0x3`, `we=1` -> `valid_o` pulse 1 cycle, `address_o=0x40`, `wdata_o=0xDEADBEEF`, `wstrb_o=0x3`. `ready_i` in the same cycle -> `wb_ack_o` for 1 cycle on the next cycle, `wb_dat_o` unchanged.
- Read `adr=0x80`, `ready_i` 3 cycles after `valid_o` with `rdata_i=0x12345678` -> `wstrb_o=0`, `valid_o` high only 1 cycle, single `wb_ack_o` cycle with `wb_dat_o=0x12345678`.
- TIMEOUT=4, no `ready_i` -> `wb_err_o` 1 cycle after the 4th cycle counted from `valid_o`, no `ack`. A late `ready_i` in IDLE with `rdata_i=0xFFFF0000` -> `wb_dat_o` keeps its old value and no `ack`.
- TIMEOUT=4, `ready_i` exactly in the 4th cycle -> `wb_ack_o`, no `wb_err_o`.
- Abort: drop `wb_cyc_i` in WAIT, then `ready_i` -> no `wb_ack_o`, and `wb_dat_o` is not updated by the read.
- Two back-to-back writes with `stb` held and `ready_i` immediate -> two `valid_o` pulses 3 cycles apart, two `acks`. `wb_rst_i` pulse in WAIT -> IDLE, all outputs 0. `arst_n_i` low mid-REQ -> `valid_o` drops immediately.

Source files
------------

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb native master bridge.
// One transfer in flight; a missing IOb response ends in wb_err_o.
module iob_wishbone2iob #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                wb_rst_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                valid_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                ready_i
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, ERR} state_t;

    state_t           state;
    logic             we;
    logic             abort;
    logic [CNT_W-1:0] cnt;
    logic             quit;
    logic             tmo_hit;

    // cnt holds the index of the current cycle, 1 being the valid_o cycle
    assign quit    = abort | ~wb_cyc_i;
    assign tmo_hit = (TIMEOUT != 0) && (cnt == TMO);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= IDLE;
            we        <= 1'b0;
            abort     <= 1'b0;
            cnt       <= '0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            valid_o   <= 1'b0;
            address_o <= '0;
            wdata_o   <= '0;
            wstrb_o   <= '0;
        end else if (wb_rst_i) begin
            state     <= IDLE;
            we        <= 1'b0;
            abort     <= 1'b0;
            cnt       <= '0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            valid_o   <= 1'b0;
            address_o <= '0;
            wdata_o   <= '0;
            wstrb_o   <= '0;
        end else begin
            valid_o  <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        address_o <= wb_adr_i;
                        wdata_o   <= wb_dat_i;
                        wstrb_o   <= wb_we_i ? wb_sel_i : '0;
                        we        <= wb_we_i;
                        abort     <= 1'b0;
                        cnt       <= CNT_W'(1);
                        valid_o   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (!wb_cyc_i) abort <= 1'b1;
                    if (ready_i) begin
                        if (!we && !quit) wb_dat_o <= rdata_i;
                        wb_ack_o <= ~quit;
                        state    <= ACK;
                    end else if (tmo_hit) begin
                        wb_err_o <= ~quit;
                        state    <= ERR;
                    end else begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        state <= WAIT;
                    end
                end
                ACK, ERR: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Directed bench for iob_wishbone2iob with TIMEOUT=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_iob_wishbone2iob;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        wb_rst;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;
    logic        valid;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    int errors = 0;
    int checks = 0;

    iob_wishbone2iob #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .wb_rst_i (wb_rst),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat_w),
        .wb_sel_i (wb_sel),
        .wb_we_i  (wb_we),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_dat_o (wb_dat_r),
        .wb_ack_o (wb_ack),
        .wb_err_o (wb_err),
        .valid_o  (valid),
        .address_o(address),
        .wdata_o  (wdata),
        .wstrb_o  (wstrb),
        .rdata_i  (rdata),
        .ready_i  (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        ready  = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; wb_rst = 1'b0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; rdata = '0; ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", valid, 0);
        chk("rst_ack", wb_ack, 0);
        chk("rst_err", wb_err, 0);
        chk("rst_dat", wb_dat_r, 0);
        chk("rst_addr", address, 0);
        arst_n = 1'b1;
        tick();

        // write with immediate ready
        wb_adr = 32'h40; wb_dat_w = 32'hDEADBEEF; wb_sel = 4'h3;
        wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        chk("wr_valid", valid, 1);
        chk("wr_addr", address, 32'h40);
        chk("wr_wdata", wdata, 32'hDEADBEEF);
        chk("wr_wstrb", wstrb, 4'h3);
        chk("wr_noack_req", wb_ack, 0);
        ready = 1'b1;
        tick();
        chk("wr_ack", wb_ack, 1);
        chk("wr_valid_drop", valid, 0);
        chk("wr_dat_keep", wb_dat_r, 0);
        idle_bus();
        tick();
        chk("wr_ack_once", wb_ack, 0);

        // read, ready in 4th cycle (counter == TIMEOUT, ready wins)
        wb_adr = 32'h80; wb_sel = 4'hF; wb_we = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        chk("rd_valid", valid, 1);
        chk("rd_wstrb", wstrb, 0);
        chk("rd_addr", address, 32'h80);
        tick();
        chk("rd_valid_once", valid, 0);
        tick();
        tick();
        chk("rd_noerr_c3", wb_err, 0);
        ready = 1'b1; rdata = 32'h12345678;
        tick();
        chk("rd_ack", wb_ack, 1);
        chk("rd_noerr", wb_err, 0);
        chk("rd_dat", wb_dat_r, 32'h12345678);
        idle_bus();
        tick();
        chk("rd_ack_once", wb_ack, 0);

        // timeout
        wb_adr = 32'hC0; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        chk("to_valid", valid, 1);
        tick();
        tick();
        tick();
        chk("to_noerr_c4", wb_err, 0);
        tick();
        chk("to_err", wb_err, 1);
        chk("to_noack", wb_ack, 0);
        idle_bus();
        tick();
        chk("to_err_once", wb_err, 0);
        ready = 1'b1; rdata = 32'hFFFF0000;
        tick();
        chk("stale_noack", wb_ack, 0);
        chk("stale_dat", wb_dat_r, 32'h12345678);
        chk("stale_novalid", valid, 0);
        ready = 1'b0;
        tick();

        // abort: drop cyc in WAIT, then ready
        wb_adr = 32'hE0; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();
        ready = 1'b1; rdata = 32'hAAAA5555;
        tick();
        chk("ab_noack", wb_ack, 0);
        chk("ab_dat", wb_dat_r, 32'h12345678);
        ready = 1'b0;
        tick();
        chk("ab_noack2", wb_ack, 0);
        chk("ab_noerr", wb_err, 0);

        // back-to-back writes with stb held
        wb_adr = 32'h100; wb_dat_w = 32'h11111111; wb_sel = 4'hF;
        wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1; ready = 1'b1;
        tick();
        chk("b2b_valid1", valid, 1);
        tick();
        chk("b2b_ack1", wb_ack, 1);
        chk("b2b_gap_v", valid, 0);
        wb_adr = 32'h104; wb_dat_w = 32'h22222222;
        tick();
        chk("b2b_idle_v", valid, 0);
        chk("b2b_idle_a", wb_ack, 0);
        tick();
        chk("b2b_valid2", valid, 1);
        chk("b2b_addr2", address, 32'h104);
        chk("b2b_wdata2", wdata, 32'h22222222);
        tick();
        chk("b2b_ack2", wb_ack, 1);
        idle_bus();
        tick();

        // synchronous wishbone reset in WAIT
        wb_adr = 32'h180; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        tick();
        wb_rst = 1'b1;
        tick();
        chk("wbr_valid", valid, 0);
        chk("wbr_addr", address, 0);
        chk("wbr_wdata", wdata, 0);
        chk("wbr_wstrb", wstrb, 0);
        chk("wbr_dat", wb_dat_r, 0);
        chk("wbr_ack", wb_ack, 0);
        chk("wbr_err", wb_err, 0);
        wb_rst = 1'b0;
        idle_bus();
        ready = 1'b1;
        tick();
        tick();
        chk("wbr_after_ack", wb_ack, 0);
        chk("wbr_after_err", wb_err, 0);
        ready = 1'b0;

        // async reset mid-REQ
        wb_adr = 32'h200; wb_dat_w = 32'h33333333; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        chk("ar_valid", valid, 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("ar_valid_drop", valid, 0);
        chk("ar_addr", address, 0);
        chk("ar_wstrb", wstrb, 0);
        idle_bus();
        #1;
        arst_n = 1'b1;
        tick();
        tick();
        chk("ar_noack", wb_ack, 0);
        chk("ar_novalid", valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
